// File: rtl/s_fetch_issue_pkg.sv
// s_fetch_issue_pkg: shared types and constants for the scalar fetch/issue unit
// Contents: fetch FSM state encoding, S_ENDPGM opcode match, PC increment.
package s_fetch_issue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] S_ENDPGM = 16'hBF81;
    localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/s_fetch_issue_if.sv
// s_fetch_issue_if: instruction-memory and issue handshake bundle
// Signals:
//   imem_req/imem_addr     fetch request and word address (fetch unit -> memory)
//   imem_rdata/imem_valid  returned instruction word (memory -> fetch unit)
//   inst/inst_pc/inst_valid issued instruction (fetch unit -> ALU)
//   inst_ready             ALU accepts the head instruction
// Modports: master = fetch unit, slave = memory/ALU side.
interface s_fetch_issue_if #(
    parameter int PC_W = 8
);

    logic            imem_req;
    logic [PC_W-3:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic            inst_valid;
    logic            inst_ready;

    modport master (
        output imem_req, imem_addr, inst, inst_pc, inst_valid,
        input  imem_rdata, imem_valid, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_pc, inst_valid,
        output imem_rdata, imem_valid, inst_ready
    );

endinterface

// File: rtl/s_fetch_fifo.sv
// s_fetch_fifo: DEPTH x W synchronous FIFO with flush and async reset to empty
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   push, din         write din at tail (caller guarantees not full)
//   pop               drop head (caller guarantees not empty)
//   flush             empty the FIFO; wins over push, a same-cycle pop is absorbed
//   dout, count, empty head word, occupancy, empty flag
module s_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_q + AW'(pop);
            wr_q  <= wr_q + AW'(push);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset: the top masks the head while empty.
    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign empty = cnt_q == '0;

endmodule

// File: rtl/s_fetch_issue.sv
// s_fetch_issue: scalar instruction fetch PC, instruction FIFO and issue handshake
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   start, start_pc         begin fetching at start_pc (honoured only in IDLE)
//   redirect, redirect_pc   SET_PC from the ALU; low two PC bits ignored
//   busy                    unit not IDLE
//   bus (master)            imem request/response and inst issue handshake
//   perf_issued, perf_stall handshake count / busy-without-instruction cycles
//                           (present only when S_FETCH_PERF_EN is defined)
// Build option: S_FETCH_PERF_EN adds the performance counters.
module s_fetch_issue
    import s_fetch_issue_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_pc,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             busy,
`ifdef S_FETCH_PERF_EN
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall,
`endif
    s_fetch_issue_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            out_q, out_d;
    logic            endp_q, endp_d;

    logic [31:0]     head_inst;
    logic [PC_W-1:0] head_pc;
    logic [CW-1:0]   count;
    logic            empty, pop, push, flush, is_end;

    s_fetch_fifo #(.DEPTH(DEPTH), .W(32 + PC_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({bus.imem_rdata, req_pc_q}),
        .dout  ({head_inst, head_pc}),
        .count (count),
        .empty (empty)
    );

    // The outstanding slot is counted against capacity, so a push never overflows.
    assign bus.imem_req   = state_q == FETCH && !out_q && count < CW'(DEPTH);
    assign bus.imem_addr  = fetch_pc_q[PC_W-1:2];
    assign bus.inst_valid = !empty;
    assign bus.inst       = empty ? '0 : head_inst;
    assign bus.inst_pc    = empty ? '0 : head_pc;
    assign busy           = state_q != IDLE;

    assign pop    = !empty && bus.inst_ready;
    assign is_end = pop && head_inst[31:16] == S_ENDPGM;
    assign flush  = is_end || (state_q == FETCH && redirect);
    assign push   = state_q == FETCH && out_q && bus.imem_valid && !flush;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        endp_d     = endp_q;
        // Outstanding after this edge: includes a request issued this very cycle.
        out_d      = bus.imem_req ? 1'b1 : (bus.imem_valid ? 1'b0 : out_q);
        if (bus.imem_req) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    fetch_pc_d = start_pc & ALIGN;
                    endp_d     = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (is_end) begin
                    endp_d  = out_d;
                    state_d = out_d ? DRAIN : IDLE;
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc & ALIGN;
                    state_d    = out_d ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                if (redirect) fetch_pc_d = redirect_pc & ALIGN;
                if (bus.imem_valid) begin
                    endp_d  = 1'b0;
                    state_d = endp_q ? IDLE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            req_pc_q   <= '0;
            out_q      <= 1'b0;
            endp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            out_q      <= out_d;
            endp_q     <= endp_d;
        end
    end

`ifdef S_FETCH_PERF_EN
    logic [31:0] issued_q, stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_q + 32'(pop);
            stall_q  <= stall_q + 32'(busy && empty);
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_s_fetch_issue.sv
// tb_s_fetch_issue: self-checking bench for s_fetch_issue with a scoreboard of issued instructions
module tb_s_fetch_issue;

    localparam int PC_W  = 8;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_pc = '0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = '0;
    logic       busy;
`ifdef S_FETCH_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    s_fetch_issue_if #(.PC_W(PC_W)) bus ();

    s_fetch_issue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_pc    (start_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy),
`ifdef S_FETCH_PERF_EN
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall),
`endif
        .bus         (bus.master)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [39:0] exp_q[$];
    int          lat      = 1;
    logic [7:0]  end_pc   = 8'hFF;
    bit          pend     = 0;
    int          cnt      = 0;
    logic [5:0]  pend_addr = '0;
    int          resp_cnt = 0;
    int          req_cnt  = 0;

    function automatic logic [31:0] word_of(input logic [7:0] pc);
        return pc == end_pc ? 32'hBF81_0000 : 32'h8000_0000 + {24'd0, pc};
    endfunction

    // Memory model: answers each request lat cycles later, in order.
    initial begin
        logic       r;
        logic [5:0] a;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;
        forever begin
            @(negedge clock);
            r = bus.imem_req;
            a = bus.imem_addr;
            @(posedge clock);
            #1;
            bus.imem_valid = 1'b0;
            if (r) begin
                pend      = 1;
                cnt       = lat;
                pend_addr = a;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend           = 0;
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = word_of({pend_addr, 2'b00});
                    resp_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // One clock; scoreboard compares every handshake against the expected queue.
    task automatic tick();
        logic [39:0] e;
        @(negedge clock);
        if (bus.imem_req) req_cnt++;
        if (bus.inst_valid && bus.inst_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue: got pc=%h inst=%h, required no issue", bus.inst_pc, bus.inst);
            end else begin
                e = exp_q.pop_front();
                if ({bus.inst_pc, bus.inst} !== e) begin
                    n_fail++;
                    $display("FAIL issue: got pc=%h inst=%h, required pc=%h inst=%h",
                             bus.inst_pc, bus.inst, e[39:32], e[31:0]);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic expect_pc(input logic [7:0] pc);
        exp_q.push_back({pc, word_of(pc)});
    endtask

    task automatic drain_q();
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
        bus.inst_ready = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected issues outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        redirect = 1'b0;
        bus.inst_ready = 1'b0;
        tick();
        tick();
        #2;
        pend = 0;
        bus.imem_valid = 1'b0;
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic start_at(input logic [7:0] pc);
        start_pc = pc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        n_checks += 6;
        if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, required 0", bus.imem_req); end
        if (bus.imem_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", bus.imem_addr); end
        if (bus.inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %h, required 0", bus.inst); end
        if (bus.inst_pc !== 8'd0) begin n_fail++; $display("FAIL reset_inst_pc: got %h, required 0", bus.inst_pc); end
        if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", bus.inst_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_basic();
        do_reset();
        lat = 1;
        end_pc = 8'hFF;
        start_at(8'h10);
        n_checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 6'h04}) begin
            n_fail++;
            $display("FAIL basic_first_req: got req=%b addr=%h, required req=1 addr=04", bus.imem_req, bus.imem_addr);
        end
        tick();
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b, required 0", bus.inst_valid); end
        tick();
        n_checks++;
        if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 8'h10}) begin
            n_fail++;
            $display("FAIL basic_valid_first: got valid=%b pc=%h, required valid=1 pc=10", bus.inst_valid, bus.inst_pc);
        end
        expect_pc(8'h10);
        expect_pc(8'h14);
        expect_pc(8'h18);
        drain_q();
    endtask

    task automatic test_full();
        do_reset();
        lat = 1;
        req_cnt = 0;
        start_at(8'h20);
        repeat (14) tick();
        n_checks += 2;
        if (req_cnt != DEPTH) begin n_fail++; $display("FAIL full_reqs: got %0d requests, required %0d", req_cnt, DEPTH); end
        if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 8'h20}) begin
            n_fail++;
            $display("FAIL full_head: got valid=%b pc=%h, required valid=1 pc=20", bus.inst_valid, bus.inst_pc);
        end
        for (int i = 0; i < DEPTH; i++) expect_pc(8'(8'h20 + 4 * i));
        drain_q();
    endtask

    task automatic test_redirect();
        do_reset();
        lat = 3;
        start_at(8'h00);
        for (int i = 0; i < 20 && !bus.inst_valid; i++) tick();
        n_checks++;
        if ({bus.inst_valid, bus.imem_req} !== 2'b11) begin
            n_fail++;
            $display("FAIL redir_setup: got valid=%b req=%b, required 1 1", bus.inst_valid, bus.imem_req);
        end
        tick();
        redirect = 1'b1;
        redirect_pc = 8'h43;
        tick();
        redirect = 1'b0;
        n_checks += 3;
        if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got valid=%b, required 0", bus.inst_valid); end
        if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_drain_req: got %b, required 0", bus.imem_req); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL redir_busy: got %b, required 1", busy); end
        expect_pc(8'h40);
        expect_pc(8'h44);
        drain_q();
    endtask

    task automatic test_endpgm();
        do_reset();
        lat = 1;
        end_pc = 8'h08;
        for (int k = 0; k < 2; k++) begin
            start_at(8'h00);
            expect_pc(8'h00);
            expect_pc(8'h04);
            expect_pc(8'h08);
            drain_q();
            req_cnt = 0;
            repeat (8) tick();
            n_checks += 3;
            if (req_cnt != 0) begin n_fail++; $display("FAIL endpgm_reqs: got %0d requests, required 0", req_cnt); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL endpgm_busy: got %b, required 0", busy); end
            if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL endpgm_valid: got %b, required 0", bus.inst_valid); end
        end
        end_pc = 8'hFF;
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1;
        start_at(8'hF8);
        expect_pc(8'hF8);
        expect_pc(8'hFC);
        expect_pc(8'h00);
        drain_q();
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 3;
        resp_cnt = 0;
        start_at(8'h00);
        for (int i = 0; i < 30 && resp_cnt < 2; i++) tick();
        tick();
        tick();
        n_checks++;
        if ({bus.inst_valid, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL rmid_setup: got valid=%b busy=%b, required 1 1", bus.inst_valid, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, bus.inst, bus.inst_pc, bus.inst_valid, busy} !== '0) begin
            n_fail++;
            $display("FAIL rmid_zero: got req=%b addr=%h inst=%h pc=%h valid=%b busy=%b, required all 0",
                     bus.imem_req, bus.imem_addr, bus.inst, bus.inst_pc, bus.inst_valid, busy);
        end
        tick();
        reset = 1'b0;
        repeat (4) tick();
        n_checks++;
        if ({bus.imem_req, bus.inst_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_late: got req=%b valid=%b busy=%b, required 0 0 0", bus.imem_req, bus.inst_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_redirect();
        test_endpgm();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s_fetch_issue.md
# s_fetch_issue

Scalar instruction fetch and issue unit: owns the fetch program counter, requests 32-bit instruction words from instruction memory, buffers them in a small FIFO and presents them to the scalar ALU through a valid/ready handshake. The unit supplies the ALU's instruction input. It also accepts the ALU's PC-redirect (SET_PC) request. It stops fetching when an S_ENDPGM instruction is issued.

## Interface
Parameters:
- PC_W, 8, byte-address width of the program counter (matches Program_Counter)
- DEPTH, 4, instruction FIFO entries (power of two, ≥2)

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse; begin fetching at start_pc (honoured only in IDLE)
- start_pc  input  PC_W  initial byte PC
- imem_req  output  1  one-cycle fetch request
- imem_addr  output  PC_W-2  word address (fetch_pc[PC_W-1:2])
- imem_rdata  input  32  returned instruction word
- imem_valid  input  1  imem_rdata valid; ≥1 cycle after imem_req, in order
- inst  output  32  instruction at FIFO head
- inst_pc  output  PC_W  byte PC of inst
- inst_valid  output  1  inst/inst_pc valid
- inst_ready  input  1  ALU accepts head when inst_valid && inst_ready
- redirect  input  1  SET_PC pulse from ALU
- redirect_pc  input  PC_W  new PC; bits [1:0] ignored (treated as 0)
- busy  output  1  state != IDLE

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE (reset state): no requests; FIFO empty; redirect ignored; start → fetch_pc = {start_pc[PC_W-1:2],2'b00}, go FETCH.
- FETCH: assert imem_req when no request outstanding and (fifo_count + outstanding) < DEPTH. At most one request is outstanding. fetch_pc += 4 on each request and wraps modulo 2^PC_W (0xFC → 0x00).
- Response: on imem_valid, push {imem_rdata, pc of that request} into the FIFO and clear outstanding.
- Issue: the FIFO head drives inst/inst_pc, and inst_valid = !empty. A pop occurs on handshake.
- Redirect in FETCH: flush the FIFO and set fetch_pc = {redirect_pc[PC_W-1:2],2'b00}. If a request is outstanding, go DRAIN; otherwise stay in FETCH.
- DRAIN: discard the next imem_valid response, then go FETCH. No requests are issued in DRAIN. A further redirect in DRAIN updates fetch_pc only.
- End of program: when an instruction with inst[31:16] == 16'hBF81 (S_ENDPGM) is popped, flush the FIFO and stop requests.
  - With nothing outstanding, go IDLE.
  - With a request outstanding, go DRAIN, then IDLE instead of FETCH (endpgm_pending flag).
- Simultaneous events:
  - Handshake and redirect in the same cycle: the head is consumed, then the flush is applied.
  - A push in the same cycle as a redirect or endpgm flush is dropped.
  - Popped S_ENDPGM together with redirect: S_ENDPGM wins.
  - start outside IDLE is ignored.
- FIFO full: no request is issued, because the outstanding slot is counted against capacity; a push therefore never overflows.

## Timing
- Reset values: imem_req=0, imem_addr=0, inst=0, inst_pc=0, inst_valid=0, busy=0. Internal state: IDLE, count=0, outstanding=0, fetch_pc=0.
- imem_req and imem_addr are combinational from registered state and counters; no input-to-output combinational path.
- With start sampled at edge N and 1-cycle memory:
  - imem_req is high in cycle N+1.
  - imem_valid in cycle N+2 pushes at edge N+2.
  - inst_valid is high in cycle N+3.
- Sustained throughput with 1-cycle memory is one instruction per 2 cycles (single outstanding request).
- Redirect at edge R: flush takes effect at R, and the first request to the new PC is in cycle R+1 if nothing was outstanding.
- Reset asserted mid-operation clears everything immediately. Any memory response arriving after reset deasserts while in IDLE is ignored.

## Configuration
- S_FETCH_PERF_EN defined adds two outputs:
  - perf_issued, 32 bits: count of handshakes.
  - perf_stall, 32 bits: cycles with busy && !inst_valid.
  - Both reset to 0, wrap at 2^32, and keep counting across IDLE/start.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package/header (alongside scalars.vh): state encodings, S_ENDPGM match constant 16'hBF81, PC increment 4.
- One sub-module: s_fetch_fifo (DEPTH×(32+PC_W) synchronous FIFO with push, pop, flush, count, and an async reset to empty).

## Test plan
- Reset then start with start_pc=0x10, 1-cycle memory returning 0x8000_0000+addr → inst_pc sequence 0x10, 0x14, 0x18 with matching words; inst_valid first high 2 cycles after the start edge.
- Hold inst_ready=0 → exactly DEPTH=4 entries fill, no fifth imem_req. Release → all four issue in order with no loss.
- Redirect to 0x43 while a request is outstanding → FIFO empties; the stale response is dropped; the next inst_pc is 0x40.
- Memory returns 0xBF81_0000 at PC 0x08, accepted → no further imem_req; busy=0 after drain; inst_valid=0. A new start at 0x00 resumes.
- start_pc=0xF8 → inst_pc sequence 0xF8, 0xFC, 0x00 (wrap).
- Reset asserted while a request is outstanding and the FIFO holds 2 entries → all outputs read 0 immediately; a late imem_valid is ignored.
